// File: rtl/fpu_pkg.sv
// Shared FPU types: operand classes, IEEE single constants and pipeline stage records.
// Used by fsquare and by the reusable round/pack stage.
package fpu_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fclass_t;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] PINF     = 32'h7F80_0000;

    typedef struct packed {
        logic        sign;
        fclass_t     cls;
        logic [7:0]  exp;
        logic [23:0] man;
    } s1_t;

    typedef struct packed {
        logic              sign;
        fclass_t           cls;
        logic signed [9:0] exp;
        logic [47:0]       prod;
    } s2_t;

    // Subnormals are flushed, so a zero exponent always classifies as ZERO.
    function automatic fclass_t classify(input logic [7:0] e, input logic [22:0] m);
        if (e == 8'h00) begin
            return ZERO;
        end else if (e == 8'hFF) begin
            return (m != 23'd0) ? NAN : INF;
        end else begin
            return NORM;
        end
    endfunction

endpackage

// File: rtl/fround_pack.sv
// Combinational normalize / round-to-nearest-even / range-check / pack of a 48-bit
// significand product; shared between the squarer and the multiplier.
module fround_pack
    import fpu_pkg::*;
#(
    parameter logic [31:0] CANON_NAN = QNAN
) (
    input  fclass_t           i_cls,
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [47:0]       i_prod,
    output logic [31:0]       o_y
);
    logic [23:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic              w_roundUp;
    logic [24:0]       w_sum;
    logic [22:0]       w_frac;
    logic signed [9:0] w_expNorm;
    logic signed [9:0] w_expFinal;

    // Product of two [1,2) significands lies in [1,4); bit 47 selects the extra shift.
    always_comb begin
        w_mant     = 24'd0;
        w_guard    = 1'b0;
        w_sticky   = 1'b0;
        w_expNorm  = i_exp;
        w_roundUp  = 1'b0;
        w_sum      = 25'd0;
        w_frac     = 23'd0;
        w_expFinal = i_exp;
        o_y        = 32'd0;

        if (i_prod[47]) begin
            w_mant    = i_prod[47:24];
            w_guard   = i_prod[23];
            w_sticky  = |i_prod[22:0];
            w_expNorm = i_exp + 10'sd1;
        end else begin
            w_mant    = i_prod[46:23];
            w_guard   = i_prod[22];
            w_sticky  = |i_prod[21:0];
            w_expNorm = i_exp;
        end

        w_roundUp = w_guard & (w_sticky | w_mant[0]);
        w_sum     = {1'b0, w_mant} + {24'd0, w_roundUp};

        if (w_sum[24]) begin
            w_frac     = w_sum[23:1];
            w_expFinal = w_expNorm + 10'sd1;
        end else begin
            w_frac     = w_sum[22:0];
            w_expFinal = w_expNorm;
        end

        if (i_cls == NAN) begin
            o_y = CANON_NAN;
        end else if (i_cls == INF) begin
            o_y = {i_sign, PINF[30:0]};
        end else if (i_cls == ZERO) begin
            o_y = {i_sign, 31'd0};
        end else if (w_expFinal >= 10'sd255) begin
            o_y = {i_sign, PINF[30:0]};
        end else if (w_expFinal <= 10'sd0) begin
            o_y = {i_sign, 31'd0};
        end else begin
            o_y = {i_sign, w_expFinal[7:0], w_frac};
        end
    end

endmodule

// File: rtl/fsquare.sv
// Three-stage pipelined IEEE-754 single-precision squarer (y = x*x).
// One enable moves every stage together, so a held output freezes the whole pipe.
module fsquare
    import fpu_pkg::*;
#(
    parameter logic [31:0] CANON_NAN = QNAN
) (
    input  logic        CLKA,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);
    logic              w_en;
    logic              r_v1;
    logic              r_v2;
    logic              r_v3;
    s1_t               r_s1;
    s2_t               r_s2;
    logic [31:0]       r_y3;
    logic [31:0]       w_y3;
    logic signed [9:0] w_exp2;
    logic [47:0]       w_prod2;

    assign w_en     = !r_v3 | out_ready;
    assign in_ready = w_en;

    // Squaring doubles the biased exponent, so the bias has to come off once.
    assign w_exp2  = $signed({1'b0, r_s1.exp, 1'b0}) - $signed(10'(EXP_BIAS));
    assign w_prod2 = {24'd0, r_s1.man} * {24'd0, r_s1.man};

    fround_pack #(
        .CANON_NAN (CANON_NAN)
    ) u_roundPack (
        .i_cls  (r_s2.cls),
        .i_sign (r_s2.sign),
        .i_exp  (r_s2.exp),
        .i_prod (r_s2.prod),
        .o_y    (w_y3)
    );

    always_ff @(posedge CLKA or negedge RST) begin
        if (!RST) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_s1 <= '0;
            r_s2 <= '0;
            r_y3 <= 32'd0;
        end else if (w_en) begin
            r_v1      <= in_valid;
            r_s1.sign <= x[31];
            r_s1.cls  <= classify(x[30:23], x[22:0]);
            r_s1.exp  <= x[30:23];
            r_s1.man  <= {1'b1, x[22:0]};

            // Product sign of an operand with itself is always positive.
            r_v2      <= r_v1;
            r_s2.sign <= r_s1.sign ^ r_s1.sign;
            r_s2.cls  <= r_s1.cls;
            r_s2.exp  <= w_exp2;
            r_s2.prod <= w_prod2;

            r_v3      <= r_v2;
            r_y3      <= w_y3;
        end
    end

    assign out_valid = r_v3;
    assign y         = r_y3;

endmodule

// File: tb/tb_fsquare.sv
// Self-checking bench for fsquare: a real-arithmetic reference model feeds a scoreboard
// that is compared every cycle, plus directed vectors with hand-computed results.
module tb_fsquare;

    logic        CLKA;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    int          checkCount;
    int          passCount;
    logic [31:0] expQ[$];
    logic        prevStall;
    logic [31:0] prevY;

    fsquare dut (
        .CLKA      (CLKA),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    initial begin
        CLKA = 1'b0;
        forever #5 CLKA = ~CLKA;
    end

    // Exact square in double precision, then rounded to single with ties-to-even.
    function automatic logic [31:0] modelSquare(input logic [31:0] xin);
        int          ex;
        int          e;
        real         v;
        real         sq;
        logic [63:0] dbits;
        logic [10:0] dexp;
        logic [22:0] keep;
        logic [28:0] rem;
        logic [24:0] mant;
        ex = int'(xin[30:23]);
        if (ex == 255) return (xin[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        if (ex == 0) return 32'h0;
        dexp  = 11'(ex + 896);
        v     = $bitstoreal({1'b0, dexp, xin[22:0], 29'd0});
        sq    = v * v;
        dbits = $realtobits(sq);
        e     = int'(dbits[62:52]) - 1023 + 127;
        keep  = dbits[51:29];
        rem   = dbits[28:0];
        mant  = {2'b01, keep};
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return 32'h7F80_0000;
        if (e <= 0) return 32'h0;
        return {1'b0, 8'(e), mant[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Single isolated transfer: pins the model, measures latency and checks the literal result.
    task automatic applyStimulus(input string name, input logic [31:0] xin, input logic [31:0] expected);
        int lat;
        checkOutput({name, "_model"}, modelSquare(xin), expected);
        x        = xin;
        in_valid = 1'b1;
        @(posedge CLKA);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge CLKA);
            if (out_valid) lat = n;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd3);
        checkOutput({name, "_y"}, y, expected);
        @(posedge CLKA);
        #1;
    endtask

    task automatic sendWord(input logic [31:0] xin);
        logic acc;
        acc      = 1'b0;
        x        = xin;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge CLKA);
            acc = in_ready;
            @(posedge CLKA);
            #1;
        end
        checkOutput("send_accept", {31'd0, acc}, 32'd1);
    endtask

    // Scoreboard compare: every cycle the output is meaningful.
    initial begin
        prevStall = 1'b0;
        prevY     = 32'd0;
        forever begin
            @(negedge CLKA);
            if (!RST) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("stall_hold_valid", {31'd0, out_valid}, 32'd1);
                    checkOutput("stall_hold_y", y, prevY);
                end
                if (out_valid && !out_ready) begin
                    checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
                if (out_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("spurious_valid", {31'd0, out_valid}, 32'd0);
                    end else begin
                        checkOutput("model_y", y, expQ[0]);
                        if (out_ready) void'(expQ.pop_front());
                    end
                end
                if (in_valid && in_ready) expQ.push_back(modelSquare(x));
                prevStall = out_valid && !out_ready;
                prevY     = y;
            end
        end
    end

    initial begin
        forever begin
            @(negedge RST);
            expQ.delete();
            prevStall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic firstSeen;

    initial begin
        checkCount = 0;
        passCount  = 0;
        RST        = 1'b0;
        in_valid   = 1'b0;
        x          = 32'd0;
        out_ready  = 1'b1;

        #2;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_y", y, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        #6 RST = 1'b1;
        @(posedge CLKA);
        #1;

        applyStimulus("two", 32'h4000_0000, 32'h4080_0000);
        applyStimulus("one_half", 32'h3FC0_0000, 32'h4010_0000);
        applyStimulus("neg_three", 32'hC040_0000, 32'h4110_0000);
        applyStimulus("round_sticky", 32'h3F80_0001, 32'h3F80_0002);
        applyStimulus("overflow", 32'h5F80_0000, 32'h7F80_0000);
        applyStimulus("underflow", 32'h1F80_0000, 32'h0000_0000);
        applyStimulus("subnormal", 32'h0000_0001, 32'h0000_0000);
        applyStimulus("neg_zero", 32'h8000_0000, 32'h0000_0000);
        applyStimulus("snan", 32'h7F80_0001, 32'h7FC0_0000);
        applyStimulus("neg_inf", 32'hFF80_0000, 32'h7F80_0000);
        applyStimulus("qnan", 32'h7FC1_2345, 32'h7FC0_0000);

        checkOutput("pin_three", modelSquare(32'h4040_0000), 32'h4110_0000);
        checkOutput("pin_four", modelSquare(32'h4080_0000), 32'h4180_0000);
        checkOutput("pin_one", modelSquare(32'h3F80_0000), 32'h3F80_0000);

        fork
            begin
                sendWord(32'h4000_0000);
                sendWord(32'h4040_0000);
                sendWord(32'h4080_0000);
                sendWord(32'h3F80_0000);
                in_valid = 1'b0;
            end
            begin
                firstSeen = 1'b0;
                for (int k = 0; k < 20 && !firstSeen; k++) begin
                    @(negedge CLKA);
                    if (out_valid) firstSeen = 1'b1;
                end
                checkOutput("bp_first_output", {31'd0, firstSeen}, 32'd1);
                @(posedge CLKA);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge CLKA);
                #1 out_ready = 1'b1;
            end
        join

        for (int k = 0; k < 30 && (expQ.size() != 0 || out_valid); k++) begin
            @(negedge CLKA);
        end
        checkOutput("bp_drained", 32'(expQ.size()), 32'd0);
        @(posedge CLKA);
        #1;

        sendWord(32'h4040_0000);
        sendWord(32'h4080_0000);
        in_valid = 1'b0;
        #1 RST = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        #1 RST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLKA);
            checkOutput("midrst_idle", {31'd0, out_valid}, 32'd0);
        end
        @(posedge CLKA);
        #1;
        applyStimulus("after_reset", 32'h4000_0000, 32'h4080_0000);

        repeat (3) @(posedge CLKA);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
